// File: rtl/nios_cpu_gpi_edge.sv
// Avalon-MM general-purpose input port with a synchroniser, per-bit debounce,
// edge capture (write-1-to-clear) and a maskable level interrupt.
module nios_cpu_gpi_edge #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_MASK = 2'd1;
  localparam logic [1:0]       ADDR_EDGE = 2'd2;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_clr;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic [31:0]      w_rdata;

  // Metastability synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      for (int unsigned b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (w_sync[b] == r_stable[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_stable[b] <= w_sync[b];
          r_cnt[b]    <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_d;
  assign w_fall = ~r_stable & r_stable_d;

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_event = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_event = w_fall;
    end else begin : g_edge_any
      assign w_event = w_rise | w_fall;
    end
  endgenerate

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic w_unused_wdata_hi;
      assign w_unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // W1C is staged one cycle so clear and a coincident capture resolve with set winning
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_irq_mask <= '0;
      r_clr      <= '0;
      r_edge_cap <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      if (w_wr && (address == ADDR_MASK)) r_irq_mask <= w_wdata;
      r_clr      <= (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;
      r_edge_cap <= (r_edge_cap & ~r_clr) | w_event;
      readdata   <= w_rdata;
      irq        <= |(r_edge_cap & r_irq_mask);
    end
  end

  // Read mux; reads are unqualified by chipselect
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata = 32'(r_stable);
      ADDR_MASK: w_rdata = 32'(r_irq_mask);
      ADDR_EDGE: w_rdata = 32'(r_edge_cap);
      default:   w_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_cpu_gpi_edge.sv
// Bench for nios_cpu_gpi_edge: four configurations driven in parallel and
// checked every cycle against a window-based behavioural model.
module tb_nios_cpu_gpi_edge;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd    [NI];
  logic        irq_v [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_cpu_gpi_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd[0]), .irq(irq_v[0]));

  nios_cpu_gpi_edge #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd[1]), .irq(irq_v[1]));

  nios_cpu_gpi_edge #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_v[2]));

  nios_cpu_gpi_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(2)) u_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[3:0]),
    .readdata(rd[3]), .irq(irq_v[3]));

  function automatic int cw(int k);
    case (k) 0: return 8; 1: return 8; 2: return 32; default: return 4; endcase
  endfunction
  function automatic int cs(int k);
    case (k) 1: return 3; default: return 2; endcase
  endfunction
  function automatic int cd(int k);
    case (k) 1: return 4; default: return 1; endcase
  endfunction
  function automatic int ce(int k);
    case (k) 0: return 0; 2: return 1; default: return 2; endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d at %0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  // Model: ih[j] is in_port sampled j edges ago; a bit's accepted level flips
  // once the synchronised view has shown the new value for D consecutive edges.
  logic [31:0] ih [8];
  logic [31:0] m_st [NI], m_stp [NI], m_mask [NI], m_cap [NI], m_pend [NI], m_rd [NI];
  logic        m_irq [NI];

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] wm, a1, a0, ns, ev, nc;
    logic        wr;
    if (!reset_n) begin
      for (int j = 0; j < 8; j++) ih[j] = '0;
      for (int k = 0; k < NI; k++) begin
        m_st[k] = '0; m_stp[k] = '0; m_mask[k] = '0; m_cap[k] = '0;
        m_pend[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
      end
    end else begin
      for (int j = 7; j > 0; j--) ih[j] = ih[j-1];
      ih[0] = in_port;
      wr = chipselect && !write_n;
      for (int k = 0; k < NI; k++) begin
        wm = (cw(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw(k)) - 32'd1);
        a1 = wm;
        a0 = wm;
        for (int j = cs(k); j < cs(k) + cd(k); j++) begin
          a1 = a1 & ih[j];
          a0 = a0 & ~ih[j];
        end
        ns = (m_st[k] | a1) & ~a0;
        case (ce(k))
          0:       ev = m_st[k] & ~m_stp[k];
          1:       ev = ~m_st[k] & m_stp[k];
          default: ev = m_st[k] ^ m_stp[k];
        endcase
        case (address)
          2'd0:    m_rd[k] = m_st[k];
          2'd1:    m_rd[k] = m_mask[k];
          2'd2:    m_rd[k] = m_cap[k];
          default: m_rd[k] = '0;
        endcase
        m_irq[k] = |(m_cap[k] & m_mask[k]);
        nc = (m_cap[k] & ~m_pend[k]) | (ev & wm);
        m_pend[k] = (wr && address == 2'd2) ? (writedata & wm) : '0;
        if (wr && address == 2'd1) m_mask[k] = writedata & wm;
        m_cap[k] = nc;
        m_stp[k] = m_st[k];
        m_st[k]  = ns;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("readdata", k, rd[k], m_rd[k]);
      chk("irq", k, 32'(irq_v[k]), 32'(m_irq[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state across the whole register map
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      chk("reset_rd", 0, rd[0], 32'h0);
      chk("reset_irq", 0, 32'(irq_v[0]), 32'h0);
    end

    // Rising-edge latency with N=2, D=1
    bus_write(2'd1, 32'h01);
    repeat (5) tick();
    address = 2'd0;
    in_port = 32'h01;
    tick(); tick(); tick();
    chk("lat_data_e2", 0, rd[0], 32'h00);
    tick();
    chk("lat_data_e3", 0, rd[0], 32'h01);
    chk("lat_irq_e3", 0, 32'(irq_v[0]), 32'h0);
    tick();
    chk("lat_irq_e4", 0, 32'(irq_v[0]), 32'h1);
    address = 2'd2;
    tick();
    chk("lat_cap", 0, rd[0], 32'h01);

    // W1C: irq drops two edges after the write
    bus_write(2'd2, 32'h01);
    chk("w1c_irq_w0", 0, 32'(irq_v[0]), 32'h1);
    tick();
    chk("w1c_irq_w1", 0, 32'(irq_v[0]), 32'h1);
    tick();
    chk("w1c_irq_w2", 0, 32'(irq_v[0]), 32'h0);
    chk("w1c_cap", 0, rd[0], 32'h00);

    // New rising capture coincides with the W1C taking effect: set wins
    in_port = 32'h00;
    repeat (10) tick();
    in_port = 32'h01;
    tick(); tick();
    bus_write(2'd2, 32'h01);
    tick(); tick();
    chk("set_wins_cap", 0, rd[0], 32'h01);

    // Debounce D=4: a 3-cycle glitch is dropped, a 4-cycle level is accepted
    in_port = 32'h00;
    repeat (15) tick();
    bus_write(2'd2, 32'hFFFF_FFFF);
    repeat (3) tick();
    in_port = 32'h08;
    repeat (3) tick();
    in_port = 32'h00;
    repeat (15) tick();
    address = 2'd0;
    tick();
    chk("glitch_data", 1, rd[1], 32'h00);
    address = 2'd2;
    tick();
    chk("glitch_cap", 1, rd[1], 32'h00);
    in_port = 32'h08;
    repeat (4) tick();
    repeat (15) tick();
    address = 2'd0;
    tick();
    chk("hold_data", 1, rd[1], 32'h08);
    address = 2'd2;
    tick();
    chk("hold_cap", 1, rd[1], 32'h08);

    // Any-edge capture of a falling bit 7, then masking
    in_port = 32'h88;
    repeat (15) tick();
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFF);
    repeat (3) tick();
    in_port = 32'h08;
    repeat (15) tick();
    address = 2'd2;
    tick();
    chk("fall7_cap", 1, rd[1], 32'h80);
    chk("fall7_irq", 1, 32'(irq_v[1]), 32'h1);
    bus_write(2'd1, 32'h00);
    chk("mask_irq_m0", 1, 32'(irq_v[1]), 32'h1);
    tick();
    chk("mask_irq_m1", 1, 32'(irq_v[1]), 32'h0);
    address = 2'd2;
    tick();
    chk("mask_cap_kept", 1, rd[1], 32'h80);

    // Width extremes and zero-filled upper bits
    in_port = 32'hA5A5_5A5A;
    repeat (10) tick();
    address = 2'd0;
    tick();
    chk("w32_data", 2, rd[2], 32'hA5A5_5A5A);
    in_port = 32'h0000_000F;
    repeat (10) tick();
    chk("w4_data", 3, rd[3], 32'h0000_000F);

    // Randomised traffic with occasional mid-run resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) in_port = in_port ^ ($urandom & $urandom & $urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
